// File: rtl/row_by_matrix_mul.sv
// row_by_matrix_mul: signed fixed-point row vector times a constant weight matrix.
// Ports: clk, rst (async active-low), packed_a (IN_D x W), packed_out (OUT_D x 2W), out_v (sticky).
//
// Inputs are W-bit two's complement. The product of two elements has
// twice as many fractional bits, so the outputs carry full-precision
// 2W-bit dot products with no rounding or shifting.
//
// Weights are held in WEIGHT_INIT, row-major. Word i*OUT_D+j is w[i][j]
// (input i -> output j). Word 0 sits in the MSBs, which is the same word
// order as a weights.hex image.
//
// Flow: LOAD captures packed_a, then MAC adds one matrix row per cycle.
// The edge that adds the last row sets out_v, and DONE then holds the
// results until the next reset.
module row_by_matrix_mul #(
    parameter int                      W           = 16,
    parameter int                      IN_D        = 4,
    parameter int                      OUT_D       = 4,
    parameter logic [IN_D*OUT_D*W-1:0] WEIGHT_INIT = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_D*W-1:0]    packed_a,
    output logic [OUT_D*2*W-1:0] packed_out,
    output logic                 out_v
);

    localparam int NW = IN_D * OUT_D;
    localparam int IW = (IN_D > 1) ? $clog2(IN_D) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(IN_D - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IN_D*W-1:0]      a_q, a_d;
    logic [OUT_D*2*W-1:0]   acc_q, acc_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic                   out_v_q, out_v_d;

    logic [W-1:0]           a_sel;
    logic [W-1:0]           w_sel;
    logic [2*W-1:0]         a_ext;
    logic [2*W-1:0]         w_ext;
    logic [2*W-1:0]         prod;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        out_v_d = out_v_q;
        a_sel   = '0;
        w_sel   = '0;
        a_ext   = '0;
        w_ext   = '0;
        prod    = '0;

        unique case (state_q)
            LOAD: begin
                a_d     = packed_a;
                acc_d   = '0;
                idx_d   = '0;
                state_d = MAC;
            end

            MAC: begin
                a_sel = a_q[(IN_D-1-int'(idx_q))*W +: W];
                a_ext = {{W{a_sel[W-1]}}, a_sel};
                for (int j = 0; j < OUT_D; j++) begin
                    w_sel = WEIGHT_INIT[(NW-1-(int'(idx_q)*OUT_D+j))*W +: W];
                    w_ext = {{W{w_sel[W-1]}}, w_sel};
                    // Both operands are sign-extended to 2W bits, so the
                    // low 2W bits of the product are the exact signed
                    // product. The accumulation wraps on overflow.
                    prod  = a_ext * w_ext;
                    acc_d[(OUT_D-1-j)*2*W +: 2*W] =
                        acc_q[(OUT_D-1-j)*2*W +: 2*W] + prod;
                end
                if (idx_q == LAST_IDX) begin
                    out_v_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            DONE: begin
                out_v_d = 1'b1;
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
            a_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            out_v_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            out_v_q <= out_v_d;
        end
    end

    // Partial sums are visible during MAC; consumers qualify with out_v.
    assign packed_out = acc_q;
    assign out_v      = out_v_q;

endmodule

// File: tb/tb_row_by_matrix_mul.sv
// tb_row_by_matrix_mul: directed bench for row_by_matrix_mul (W=16, 2x2).
// Checks a behavioural model every cycle, plus hand-computed literal results.
module tb_row_by_matrix_mul;

    localparam int W  = 16;
    localparam int ID = 2;
    localparam int OD = 2;

    // Weight matrix [1, 2], [-1, 0.5] in Q4.12, written as plain integers.
    localparam int WT [ID][OD] = '{'{4096, 8192}, '{-4096, 2048}};

    logic           clk;
    logic           rst;
    logic [31:0]    a;
    logic [63:0]    packed_out;
    logic           out_v;

    logic           rst_b;
    logic [31:0]    a_b;
    logic [63:0]    packed_out_b;
    logic           out_v_b;

    int             checks;
    int             errors;

    int                   edges;
    logic signed [15:0]   a_cap [ID];

    row_by_matrix_mul #(
        .W          (W),
        .IN_D       (ID),
        .OUT_D      (OD),
        .WEIGHT_INIT(64'h1000_2000_F000_0800)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .packed_a   (a),
        .packed_out (packed_out),
        .out_v      (out_v)
    );

    row_by_matrix_mul #(
        .W          (W),
        .IN_D       (ID),
        .OUT_D      (OD),
        .WEIGHT_INIT({4{16'h8000}})
    ) dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .packed_a   (a_b),
        .packed_out (packed_out_b),
        .out_v      (out_v_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: count rising edges since reset release and remember the
    // vector present at the first one.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edges <= 0;
        end else begin
            if (edges == 0) begin
                for (int i = 0; i < ID; i++)
                    a_cap[i] <= a[(ID-1-i)*W +: W];
            end
            if (edges < 1000)
                edges <= edges + 1;
        end
    end

    // Rows accumulated so far: none through the capture edge, then one
    // per edge up to ID.
    function automatic int terms();
        int k;
        k = (edges <= 1) ? 0 : edges - 1;
        if (k > ID)
            k = ID;
        return k;
    endfunction

    function automatic logic [63:0] model_out(input int k);
        logic [63:0] r;
        longint      s;
        r = '0;
        for (int j = 0; j < OD; j++) begin
            s = 0;
            for (int i = 0; i < k; i++)
                s += longint'(a_cap[i]) * longint'(WT[i][j]);
            r[(OD-1-j)*32 +: 32] = s[31:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        check("model out_v", {63'd0, out_v},
              {63'd0, (edges >= ID + 1)});
        check("model packed_out", packed_out, model_out(terms()));
    end

    localparam logic [63:0] T1_OUT = 64'h0080_0000_0240_0000;

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        rst_b  = 1'b0;
        a      = '0;
        a_b    = '0;

        #3;
        check("reset out_v", {63'd0, out_v}, 64'd0);
        check("reset packed_out", packed_out, 64'd0);

        // Test 1/2: basic result and latency.
        a = {16'h1000, 16'h0800};
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("t2 out_v after edge 2", {63'd0, out_v}, 64'd0);
        @(posedge clk);
        #1 check("t1 out_v edge 3", {63'd0, out_v}, 64'd1);
        check("t1 packed_out", packed_out, T1_OUT);
        repeat (20) @(posedge clk);
        #1 check("t2 out_v sticky", {63'd0, out_v}, 64'd1);
        check("t2 packed_out held", packed_out, T1_OUT);

        // Test 4: input changes after capture are ignored.
        rst = 1'b0;
        #1 a = {16'h1000, 16'h0800};
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #2 a = {16'h7FFF, 16'h7FFF};
        repeat (2) @(posedge clk);
        #1 check("t4 out_v", {63'd0, out_v}, 64'd1);
        check("t4 packed_out", packed_out, T1_OUT);

        // Test 3: most negative input, sign extension.
        rst = 1'b0;
        #1 a = {16'h8000, 16'h0000};
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("t3 out_v", {63'd0, out_v}, 64'd1);
        check("t3 packed_out", packed_out, 64'hF800_0000_F000_0000);

        // Test 5: asynchronous reset during MAC.
        rst = 1'b0;
        #1 a = {16'h1000, 16'h0800};
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 check("t5 partial before reset", packed_out,
                 64'h0100_0000_0200_0000);
        rst = 1'b0;
        #1 check("t5 async out_v", {63'd0, out_v}, 64'd0);
        check("t5 async packed_out", packed_out, 64'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("t5 out_v edge 2", {63'd0, out_v}, 64'd0);
        @(posedge clk);
        #1 check("t5 out_v edge 3", {63'd0, out_v}, 64'd1);
        check("t5 packed_out", packed_out, T1_OUT);

        // Test 6: wrap-around with no saturation.
        check("t6 reset out_v", {63'd0, out_v_b}, 64'd0);
        a_b = {16'h8000, 16'h8000};
        @(negedge clk);
        #1 rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("t6 out_v edge 2", {63'd0, out_v_b}, 64'd0);
        check("t6 partial", packed_out_b, 64'h4000_0000_4000_0000);
        @(posedge clk);
        #1 check("t6 out_v", {63'd0, out_v_b}, 64'd1);
        check("t6 packed_out", packed_out_b, 64'h8000_0000_8000_0000);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
